// File: rtl/piece_mover_if.sv
// piece_mover_if: scancode in, playfield bitmap, bar position and status pulses out
interface piece_mover_if #(
  parameter int COLS = 20,
  parameter int ROWS = 20
);
  logic [7:0]               ps2_out;
  logic [COLS*ROWS-1:0]     field;
  logic [$clog2(COLS)-1:0]  col;
  logic [$clog2(ROWS)-1:0]  row;
  logic                     moved;
  logic                     blocked;
  logic                     busy;
  modport master (output ps2_out, input field, col, row, moved, blocked, busy);
  modport slave  (input ps2_out, output field, col, row, moved, blocked, busy);
endinterface

// File: rtl/piece_mover.sv
// piece_mover: moves a horizontal bar one cell per accepted scancode, with bounds checks and hold-off
module piece_mover #(
  parameter int COLS = 20,
  parameter int ROWS = 20,
  parameter int PIECE_W = 3,
  parameter int INIT_COL = 8,
  parameter int INIT_ROW = 3,
  parameter int HOLDOFF = 5000000,
  parameter logic [7:0] KEY_COL_INC = 8'h34,
  parameter logic [7:0] KEY_COL_DEC = 8'h23,
  parameter logic [7:0] KEY_ROW_DEC = 8'h2d,
  parameter logic [7:0] KEY_ROW_INC = 8'h2b
) (
  input logic clock,
  input logic reset,
  piece_mover_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N = COLS * ROWS;
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [N-1:0] BAR = N'({PIECE_W{1'b1}});
  localparam logic [CW-1:0] CMAX = CW'(COLS - PIECE_W);
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [1:0] IDLE = 2'd0, MOVE = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [7:0] key;
  logic [HW-1:0] cnt;
  logic [CW-1:0] col_q, col_n;
  logic [RW-1:0] row_q, row_n;
  logic [N-1:0] field_q;
  logic moved_q, blocked_q, legal, is_key;
  function automatic logic [N-1:0] build(input logic [CW-1:0] c, input logic [RW-1:0] r);
    return BAR << (int'(r) * COLS + int'(c));
  endfunction
  always_comb begin
    is_key = bus.ps2_out == KEY_COL_INC || bus.ps2_out == KEY_COL_DEC ||
             bus.ps2_out == KEY_ROW_INC || bus.ps2_out == KEY_ROW_DEC;
    legal = key == KEY_COL_INC ? col_q < CMAX :
            key == KEY_COL_DEC ? col_q != '0 :
            key == KEY_ROW_INC ? row_q < RMAX : row_q != '0;
    col_n = key == KEY_COL_INC ? col_q + CW'(1) : key == KEY_COL_DEC ? col_q - CW'(1) : col_q;
    row_n = key == KEY_ROW_INC ? row_q + RW'(1) : key == KEY_ROW_DEC ? row_q - RW'(1) : row_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      key <= '0;
      cnt <= '0;
      col_q <= CW'(INIT_COL);
      row_q <= RW'(INIT_ROW);
      field_q <= build(CW'(INIT_COL), RW'(INIT_ROW));
      moved_q <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      blocked_q <= 1'b0;
      if (state == IDLE && is_key) begin
        key <= bus.ps2_out;
        state <= MOVE;
      end
      if (state == MOVE) begin
        state <= HOLD;
        cnt <= HW'(HOLDOFF - 1);
        moved_q <= legal;
        blocked_q <= !legal;
        if (legal) begin
          col_q <= col_n;
          row_q <= row_n;
          field_q <= build(col_n, row_n);
        end
      end
      if (state == HOLD) begin
        if (cnt == '0) state <= IDLE;
        else cnt <= cnt - HW'(1);
      end
    end
  end
  assign bus.field = field_q;
  assign bus.col = col_q;
  assign bus.row = row_q;
  assign bus.moved = moved_q;
  assign bus.blocked = blocked_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: directed plus randomized scancodes against a cycle-level behavioural model
module tb_piece_mover;
  localparam int COLS = 8, ROWS = 4, PW = 3, IC = 2, IR = 1, HOLD = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0, n_fail = 0;
  int mc, mr, lock;
  bit pend, mm, mb;
  logic [7:0] pk;
  piece_mover_if #(.COLS(COLS), .ROWS(ROWS)) pm ();
  piece_mover #(.COLS(COLS), .ROWS(ROWS), .PIECE_W(PW), .INIT_COL(IC), .INIT_ROW(IR), .HOLDOFF(HOLD))
    dut (.clock(clock), .reset(reset), .bus(pm.slave));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_field(input int c, input int r);
    logic [31:0] f = '0;
    for (int i = 0; i < PW; i++) f[r * COLS + c + i] = 1'b1;
    return f;
  endfunction
  function automatic bit is_key(input logic [7:0] v);
    return v == 8'h34 || v == 8'h23 || v == 8'h2d || v == 8'h2b;
  endfunction
  task automatic model(input logic [7:0] v, input bit r);
    mm = 0;
    mb = 0;
    if (r) begin
      mc = IC; mr = IR; lock = 0; pend = 0;
    end else if (pend) begin
      int nc = mc, nr = mr;
      if (pk == 8'h34) nc = mc + 1;
      if (pk == 8'h23) nc = mc - 1;
      if (pk == 8'h2b) nr = mr + 1;
      if (pk == 8'h2d) nr = mr - 1;
      if (nc >= 0 && nc + PW <= COLS && nr >= 0 && nr < ROWS) begin
        mc = nc; mr = nr; mm = 1;
      end else mb = 1;
      pend = 0;
      lock = HOLD;
    end else if (lock > 0) lock--;
    else if (is_key(v)) begin
      pend = 1; pk = v;
    end
  endtask
  task automatic cyc(input logic [7:0] v, input bit r);
    pm.ps2_out = v;
    reset = r;
    @(posedge clock);
    #1;
    model(v, r);
    check("field", pm.field, exp_field(mc, mr));
    check("col", pm.col, mc);
    check("row", pm.row, mr);
    check("moved", pm.moved, mm);
    check("blocked", pm.blocked, mb);
    check("busy", pm.busy, pend || lock > 0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && pm.busy; i++) cyc(8'h00, 0);
    check("idle_timeout", pm.busy, 0);
  endtask
  task automatic send(input logic [7:0] v);
    cyc(v, 0);
    cyc(8'h00, 0);
    wait_idle();
  endtask
  initial begin
    int busy_n;
    logic [7:0] keys [4] = '{8'h34, 8'h23, 8'h2d, 8'h2b};
    pm.ps2_out = 8'h00;
    cyc(8'h00, 1);
    check("rst_field", pm.field, 32'h00001C00);
    check("rst_col", pm.col, 2);
    check("rst_row", pm.row, 1);
    check("rst_moved", pm.moved, 0);
    check("rst_busy", pm.busy, 0);
    cyc(8'h34, 0);
    cyc(8'h00, 0);
    check("inc_field", pm.field, 32'h00003800);
    check("inc_col", pm.col, 3);
    check("inc_moved", pm.moved, 1);
    busy_n = 2;
    for (int i = 0; i < 20 && pm.busy; i++) begin
      cyc(8'h00, 0);
      if (pm.busy) busy_n++;
    end
    check("busy_len", busy_n, HOLD + 1);
    send(8'h34);
    send(8'h34);
    check("at_edge_col", pm.col, 5);
    cyc(8'h34, 0);
    cyc(8'h00, 0);
    check("edge_blocked", pm.blocked, 1);
    check("edge_field", pm.field, 32'h0000E000);
    wait_idle();
    cyc(8'h00, 1);
    send(8'h2d);
    check("up_field", pm.field, 32'h0000001C);
    cyc(8'h2d, 0);
    cyc(8'h00, 0);
    check("top_blocked", pm.blocked, 1);
    check("top_field", pm.field, 32'h0000001C);
    wait_idle();
    cyc(8'h2b, 0);
    cyc(8'h00, 0);
    cyc(8'h23, 0);
    cyc(8'h00, 0);
    wait_idle();
    check("drop_row", pm.row, 1);
    check("drop_col", pm.col, 2);
    cyc(8'hF0, 0);
    cyc(8'h00, 0);
    cyc(8'h1C, 0);
    check("ignore_busy", pm.busy, 0);
    cyc(8'h34, 0);
    cyc(8'h00, 0);
    cyc(8'h00, 0);
    cyc(8'h00, 1);
    check("rst_hold_field", pm.field, 32'h00001C00);
    check("rst_hold_busy", pm.busy, 0);
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom_range(0, 9);
      logic [7:0] v = sel < 6 ? keys[$urandom_range(0, 3)] : sel == 6 ? 8'h00 : sel == 7 ? 8'hF0 : 8'($urandom);
      cyc(v, $urandom_range(0, 149) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
